// File: rtl/inst_cache_pkg.sv
// Shared I-cache refill definitions: geometry, FSM state encoding and line type.
package inst_cache_pkg;

    localparam int unsigned LINE  = 128;
    localparam int unsigned BLOCK = 8;
    localparam int unsigned IDX_W = $clog2(LINE);
    localparam int unsigned OFF_W = $clog2(BLOCK) + 2;
    localparam int unsigned CNT_W = $clog2(BLOCK);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    typedef logic [32*BLOCK-1:0] line_t;

endpackage

// File: rtl/refill_line_buf.sv
// Line buffer for one refill: beats are written at the running beat count, whole line read flat.
module refill_line_buf
    import inst_cache_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [31:0]      wdata,
    output logic [CNT_W-1:0] count,
    output line_t            line
);

    logic [31:0] words [BLOCK];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (wr_en) begin
            count <= count + CNT_W'(1);
        end
    end

    // Storage needs no reset: it is only observed after a full line has been written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            words[count] <= wdata;
        end
    end

    always_comb begin
        line = '0;
        for (int unsigned i = 0; i < BLOCK; i++) begin
            line[32*i +: 32] = words[i];
        end
    end

endmodule

// File: rtl/inst_refill_unit.sv
// I-cache miss refill engine: one INCR burst per miss, single-cycle line write, critical-word forward.
module inst_refill_unit
    import inst_cache_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               miss_valid,
    input  logic [31:0]        miss_addr,
    output logic               miss_ready,
    output logic               ar_valid,
    output logic [31:0]        ar_addr,
    output logic [7:0]         ar_len,
    input  logic               ar_ready,
    input  logic               r_valid,
    input  logic [31:0]        r_data,
    input  logic               r_last,
    output logic               r_ready,
    output logic               ram_en,
    output logic [4*BLOCK-1:0] ram_wen,
    output logic [IDX_W-1:0]   ram_index,
    output line_t              ram_wdata,
    output logic               crit_valid,
    output logic [31:0]        crit_data,
    output logic               refill_done,
    output logic               bus_err
);

    state_t           state;
    logic [31:2]      addr_q;
    logic [CNT_W-1:0] count;
    line_t            line;
    logic             beat;
    logic             last_cnt;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^miss_addr[1:0];

    assign beat     = r_valid & r_ready;
    assign last_cnt = (count == CNT_W'(BLOCK - 1));

    refill_line_buf u_buf (
        .clk    (clk),
        .resetn (resetn),
        .clr    ((state == S_AR) & ar_ready),
        .wr_en  (beat),
        .wdata  (r_data),
        .count  (count),
        .line   (line)
    );

    assign ar_addr   = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
    assign ar_len    = 8'(BLOCK - 1);
    assign ram_index = addr_q[OFF_W+IDX_W-1:OFF_W];
    assign ram_wen   = {(4*BLOCK){ram_en}};
    assign ram_wdata = ram_en ? line : '0;

    assign crit_valid = beat && (count == addr_q[OFF_W-1:2]);
    assign crit_data  = crit_valid ? r_data : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            miss_ready  <= 1'b1;
            ar_valid    <= 1'b0;
            r_ready     <= 1'b0;
            ram_en      <= 1'b0;
            refill_done <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            // Framing is only reported; completion follows the beat count alone.
            if (beat && (r_last != last_cnt)) begin
                bus_err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (miss_valid) begin
                        addr_q     <= miss_addr[31:2];
                        miss_ready <= 1'b0;
                        ar_valid   <= 1'b1;
                        state      <= S_AR;
                    end
                end
                S_AR: begin
                    if (ar_ready) begin
                        ar_valid <= 1'b0;
                        r_ready  <= 1'b1;
                        state    <= S_RD;
                    end
                end
                S_RD: begin
                    if (beat && last_cnt) begin
                        r_ready <= 1'b0;
                        ram_en  <= 1'b1;
                        state   <= S_WR;
                    end
                end
                S_WR: begin
                    ram_en      <= 1'b0;
                    refill_done <= 1'b1;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    refill_done <= 1'b0;
                    miss_ready  <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_refill_unit.sv
// Self-checking bench for inst_refill_unit: randomized bus timing against a transaction-level model.
module tb_inst_refill_unit;

    logic         clk = 1'b0;
    logic         resetn;
    logic         miss_valid;
    logic [31:0]  miss_addr;
    logic         miss_ready;
    logic         ar_valid;
    logic [31:0]  ar_addr;
    logic [7:0]   ar_len;
    logic         ar_ready;
    logic         r_valid;
    logic [31:0]  r_data;
    logic         r_last;
    logic         r_ready;
    logic         ram_en;
    logic [31:0]  ram_wen;
    logic [6:0]   ram_index;
    logic [255:0] ram_wdata;
    logic         crit_valid;
    logic [31:0]  crit_data;
    logic         refill_done;
    logic         bus_err;

    inst_refill_unit dut (
        .clk         (clk),
        .resetn      (resetn),
        .miss_valid  (miss_valid),
        .miss_addr   (miss_addr),
        .miss_ready  (miss_ready),
        .ar_valid    (ar_valid),
        .ar_addr     (ar_addr),
        .ar_len      (ar_len),
        .ar_ready    (ar_ready),
        .r_valid     (r_valid),
        .r_data      (r_data),
        .r_last      (r_last),
        .r_ready     (r_ready),
        .ram_en      (ram_en),
        .ram_wen     (ram_wen),
        .ram_index   (ram_index),
        .ram_wdata   (ram_wdata),
        .crit_valid  (crit_valid),
        .crit_data   (crit_data),
        .refill_done (refill_done),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Transaction-level model: which handshake phase the refill is in, plus the beats received.
    bit          m_idle, m_ar, m_rd, m_wr, m_done, m_err, m_finished;
    logic [31:0] m_addr;
    logic [31:0] m_beats[$];

    int unsigned  crit_pulses, wr_cycles;
    logic [31:0]  cap_ar, cap_crit, cap_wen;
    logic [6:0]   cap_index;
    logic [255:0] cap_wdata;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_idle = 1'b1; m_ar = 1'b0; m_rd = 1'b0; m_wr = 1'b0; m_done = 1'b0;
        m_err  = 1'b0;
        m_addr = '0;
        m_beats.delete();
    endtask

    function automatic logic [255:0] model_line();
        logic [255:0] l;
        l = '0;
        for (int i = 0; i < m_beats.size(); i++) l[32*i +: 32] = m_beats[i];
        return l;
    endfunction

    // Called just after inputs are driven on a falling edge; checks, then advances the model
    // by the handshakes that the next rising edge will complete.
    task automatic step();
        bit exp_crit;
        bit n_idle, n_ar, n_rd, n_wr, n_done;
        #1;
        if (!resetn) model_reset();
        exp_crit = m_rd && r_valid && (m_beats.size() == int'(m_addr[4:2]));
        chk("miss_ready",  miss_ready,  m_idle);
        chk("ar_valid",    ar_valid,    m_ar);
        chk("r_ready",     r_ready,     m_rd);
        chk("ram_en",      ram_en,      m_wr);
        chk("refill_done", refill_done, m_done);
        chk("bus_err",     bus_err,     m_err);
        chk("ar_len",      ar_len,      8'd7);
        chk("crit_valid",  crit_valid,  exp_crit);
        chk("crit_data",   crit_data,   exp_crit ? r_data : 32'h0);
        chk("ram_wen",     ram_wen,     m_wr ? 32'hFFFF_FFFF : 32'h0);
        chk("ram_wdata",   ram_wdata,   m_wr ? model_line() : 256'h0);
        if (m_ar || !resetn) chk("ar_addr", ar_addr, {m_addr[31:5], 5'b0});
        if (m_wr || !resetn) chk("ram_index", ram_index, m_addr[11:5]);
        if (crit_valid) begin crit_pulses++; cap_crit = crit_data; end
        if (ram_en) begin wr_cycles++; cap_index = ram_index; cap_wdata = ram_wdata; cap_wen = ram_wen; end
        if (ar_valid) cap_ar = ar_addr;
        if (resetn) begin
            n_idle = m_idle; n_ar = m_ar; n_rd = m_rd; n_wr = 1'b0; n_done = 1'b0;
            if (m_idle && miss_valid) begin
                n_idle = 1'b0; n_ar = 1'b1; m_addr = miss_addr;
                crit_pulses = 0; wr_cycles = 0;
            end
            if (m_ar && ar_ready) begin
                n_ar = 1'b0; n_rd = 1'b1; m_beats.delete();
            end
            if (m_rd && r_valid) begin
                if (r_last != (m_beats.size() == 7)) m_err = 1'b1;
                m_beats.push_back(r_data);
                if (m_beats.size() == 8) begin n_rd = 1'b0; n_wr = 1'b1; end
            end
            if (m_wr) n_done = 1'b1;
            if (m_done) begin n_idle = 1'b1; m_finished = 1'b1; end
            m_idle = n_idle; m_ar = n_ar; m_rd = n_rd; m_wr = n_wr; m_done = n_done;
        end
        @(negedge clk);
    endtask

    task automatic run_refill(input logic [31:0] addr, input int ar_wait, input int gap_pct,
                              input int last_pos, input logic [31:0] dbase, input bit rnd_data,
                              input int abort_after);
        logic [31:0] data [8];
        int ar_seen;
        int k;
        for (int i = 0; i < 8; i++) data[i] = rnd_data ? $urandom : dbase + 32'(i);
        m_finished = 1'b0;
        ar_seen    = 0;
        miss_valid = 1'b1; miss_addr = addr;
        step();
        miss_valid = 1'b0; miss_addr = $urandom;
        for (int cyc = 0; cyc < 300 && !m_finished; cyc++) begin
            if (abort_after >= 0 && m_rd && m_beats.size() == abort_after) begin
                resetn = 1'b0; r_valid = 1'b0;
                step();
                step();
                resetn = 1'b1;
                step();
                return;
            end
            ar_ready = m_ar ? (ar_seen >= ar_wait) : 1'($urandom);
            if (m_ar) ar_seen++;
            r_valid = ($urandom % 100) >= 32'(gap_pct);
            k       = m_beats.size();
            r_data  = m_rd ? data[k % 8] : $urandom;
            r_last  = m_rd ? (k == last_pos) : 1'($urandom);
            step();
        end
        chk("refill_finished", m_finished, 1'b1);
        chk("crit_pulses", crit_pulses, 1);
        chk("wr_cycles", wr_cycles, 1);
        ar_ready = 1'b0; r_valid = 1'b0; r_last = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; miss_valid = 1'b0; miss_addr = '0;
        ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_last = 1'b0;
        model_reset();
        m_finished = 1'b0; crit_pulses = 0; wr_cycles = 0;
        @(negedge clk);

        // Reset state
        step();
        step();
        resetn = 1'b1;
        step();

        // Basic miss, zero-wait bus
        run_refill(32'h1FC0_0124, 0, 0, 7, 32'hA0, 1'b0, -1);
        chk("basic_ar_addr", cap_ar, 32'h1FC0_0120);
        chk("basic_crit", cap_crit, 32'hA1);
        chk("basic_index", cap_index, 7'h09);
        chk("basic_wen", cap_wen, 32'hFFFF_FFFF);
        chk("basic_wdata", cap_wdata,
            256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0);

        // Backpressure on both channels
        run_refill(32'h2345_6788, 3, 40, 7, 32'hC0, 1'b0, -1);
        chk("bp_ar_addr", cap_ar, 32'h2345_6780);

        // Last-word miss
        run_refill(32'h0000_0FFC, 0, 0, 7, 32'hB0, 1'b0, -1);
        chk("last_crit", cap_crit, 32'hB7);
        chk("last_index", cap_index, 7'h7F);

        // Framing error stays sticky across a clean refill
        run_refill(32'h0000_1040, 1, 20, 5, 32'hD0, 1'b0, -1);
        chk("framing_bus_err", bus_err, 1'b1);
        run_refill(32'h0000_2000, 0, 0, 7, 32'hE0, 1'b0, -1);
        chk("sticky_bus_err", bus_err, 1'b1);

        // Reset mid-burst, then a clean refill
        run_refill(32'h0000_3008, 0, 10, 7, 32'h10, 1'b0, 3);
        chk("abort_bus_err", bus_err, 1'b0);
        run_refill(32'h0000_3008, 0, 10, 7, 32'h20, 1'b0, -1);
        chk("post_abort_crit", cap_crit, 32'h22);

        // Randomized refills
        for (int n = 0; n < 40; n++) begin
            run_refill($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 50)),
                       ($urandom % 5 == 0) ? int'($urandom_range(0, 7)) : 7,
                       32'h0, 1'b1, ($urandom % 8 == 0) ? int'($urandom_range(0, 7)) : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
